rgb_fade_ctrl: RTL
==================

RGB_FADE_CTRL -- requirements
Module: rgb_fade_ctrl

Interface
REQ-001 SHALL have parameter PERIOD_W, default 16, width of the step-period input and internal tick timer.
REQ-002 SHALL have port clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  in  1  synchronous active-high reset.
REQ-004 SHALL have port start_i  in  1  single-cycle request to fade toward the current tgt_*_i values.
REQ-005 SHALL have port stop_i  in  1  single-cycle request to abort the fade in progress.
REQ-006 SHALL have ports tgt_r_i / tgt_g_i / tgt_b_i  in  8 each  target duty per channel.
REQ-007 SHALL have port period_i  in  PERIOD_W  clock cycles between fade steps; 0 is treated as 1.
REQ-008 SHALL have port cur_o  out  24  shadow of the duties last written, {r,g,b}, r in [23:16].
REQ-009 SHALL have ports busy_o  out  1  fade active, and done_o  out  1  one-cycle pulse on fade completion.
REQ-010 SHALL have wishbone B4 controller ports: wb_cyc_o out 1, wb_stb_o out 1, wb_we_o out 1, wb_adr_o out 4, wb_dat_o out 8, wb_ack_i in 1; target is the PWM peripheral (adr 0 = R, 1 = G, 2 = B).

Function
REQ-011 SHALL implement states IDLE, WAIT, WRITE only.
REQ-012 In IDLE, start_i=1 SHALL latch tgt_*_i and max(period_i,1) (P) and, if cur_o equals the latched target, pulse done_o the next cycle with no bus activity and stay IDLE; otherwise enter WAIT with timer = P-1 and busy_o=1.
REQ-013 In WAIT, the timer SHALL decrement once per cycle; in the cycle it reads 0, each channel SHALL move one LSB toward its target (unchanged if equal), and the state SHALL go to WRITE.
REQ-014 WRITE SHALL issue one write per changed channel, in order R, G, B, skipping unchanged channels.
REQ-015 Each write SHALL assert wb_cyc_o=wb_stb_o=wb_we_o=1 with wb_adr_o/wb_dat_o stable, held until wb_ack_i=1 is sampled; the next write MAY start the cycle immediately after the ack.
REQ-016 With a combinational-ack peripheral, each write SHALL take exactly one cycle; no timeout, and stb SHALL hold indefinitely without ack.
REQ-017 After the last ack of a step, if cur_o equals the target, the block SHALL pulse done_o for one cycle, drop busy_o, and return to IDLE; otherwise it SHALL return to WAIT with timer = P-1.
REQ-018 First wb_stb_o of a fade SHALL be asserted exactly P+1 cycles after the cycle that sampled start_i.
REQ-019 Step arithmetic SHALL be unsigned 8-bit, with no overshoot or wrap (0->255 takes exactly 255 steps; 255->0 likewise).
REQ-020 start_i while busy SHALL re-latch targets and period; the new target SHALL apply from the next step computation; the running timer and any in-flight write SHALL be unaffected.
REQ-021 stop_i in WAIT SHALL return to IDLE next cycle with no done_o.
REQ-022 stop_i in WRITE SHALL let the current write complete at its ack, skip the remaining channels, then enter IDLE with no done_o; cur_o SHALL reflect only acked writes.
REQ-023 Simultaneous start_i and stop_i SHALL be resolved as stop_i wins.
REQ-024 Outside a write, wb_cyc_o, wb_stb_o and wb_we_o SHALL be 0, and wb_adr_o/wb_dat_o SHALL hold their last values.

Reset
REQ-025 rst_i SHALL force state IDLE, cur_o=0, latched targets=0, timer=0, busy_o=0, done_o=0, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=0, wb_dat_o=0 on the next edge, including mid-write (stb drops without waiting for ack).
REQ-026 rst_i SHALL take priority over start_i and stop_i.

Verification
REQ-027 Reset, then start with tgt=(2,0,1), period=3, combinational ack -> stb first high 4 cycles after start; writes (0,1),(2,1),[wait],(0,2); done_o pulses once; cur_o=0x020001.
REQ-028 Start with tgt equal to cur_o -> done_o pulses next cycle; wb_stb_o never asserted; busy_o stays 0.
REQ-029 Fade 0->255 on R only, period=0 -> exactly 255 writes to adr 0, data 1..255, no wrap; done_o once.
REQ-030 Hold wb_ack_i low for 10 cycles during a G write, assert stop_i mid-wait -> stb, adr 1 and data stable for all 10 cycles; IDLE after the ack; no done_o; cur_o G updated.
REQ-031 Assert rst_i while wb_stb_o=1 -> next cycle stb=cyc=0, cur_o=0, busy_o=0.
REQ-032 Retarget mid-fade (R 0->10, restart with 0 after R=4) -> R decreases 4,3,2,1,0 with no extra increments; a single done_o pulse.

Source files
------------

// File: rtl/rgb_fade_ctrl.sv
// RGB fade controller: steps three 8-bit PWM duties one LSB at a time toward a
// target, pushing each changed channel to the PWM peripheral over Wishbone.
module rgb_fade_ctrl #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic [7:0]          tgt_r_i,
    input  logic [7:0]          tgt_g_i,
    input  logic [7:0]          tgt_b_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic [23:0]         cur_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [3:0]          wb_adr_o,
    output logic [7:0]          wb_dat_o,
    input  logic                wb_ack_i
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_WRITE} state_t;

    localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

    // Channel index 0/1/2 = R/G/B, which is also the peripheral register address.
    state_t                state_q, state_d;
    logic [7:0]            cur_q  [3];
    logic [7:0]            cur_d  [3];
    logic [7:0]            tgt_q  [3];
    logic [7:0]            tgt_d  [3];
    logic [7:0]            nxt_q  [3];
    logic [7:0]            nxt_d  [3];
    logic [2:0]            pend_q, pend_d;
    logic [1:0]            ch_q, ch_d;
    logic [PERIOD_W-1:0]   per_q, per_d;
    logic [PERIOD_W-1:0]   timer_q, timer_d;
    logic                  stop_q, stop_d;
    logic                  done_q, done_d;
    logic [3:0]            adr_q, adr_d;
    logic [7:0]            dat_q, dat_d;

    logic                  start_ok;
    logic [PERIOD_W-1:0]   per_new;

    function automatic logic [7:0] step_toward(input logic [7:0] c, input logic [7:0] t);
        if (c < t)      return c + 8'd1;
        else if (c > t) return c - 8'd1;
        else            return c;
    endfunction

    function automatic logic [1:0] first_idx(input logic [2:0] p);
        if (p[0])      return 2'd0;
        else if (p[1]) return 2'd1;
        else           return 2'd2;
    endfunction

    assign cur_o    = {cur_q[0], cur_q[1], cur_q[2]};
    assign busy_o   = (state_q != ST_IDLE);
    assign done_o   = done_q;
    assign wb_cyc_o = (state_q == ST_WRITE);
    assign wb_stb_o = (state_q == ST_WRITE);
    assign wb_we_o  = (state_q == ST_WRITE);
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;

    // stop_i takes precedence over a simultaneous start_i.
    assign start_ok = start_i && !stop_i;
    assign per_new  = (period_i == '0) ? ONE : period_i;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path can infer a latch.
        state_d = state_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        nxt_d   = nxt_q;
        pend_d  = pend_q;
        ch_d    = ch_q;
        per_d   = per_q;
        timer_d = timer_q;
        stop_d  = stop_q;
        done_d  = 1'b0;
        adr_d   = adr_q;
        dat_d   = dat_q;

        if (start_ok) begin
            tgt_d[0] = tgt_r_i;
            tgt_d[1] = tgt_g_i;
            tgt_d[2] = tgt_b_i;
            per_d    = per_new;
        end

        unique case (state_q)
            ST_IDLE: begin
                stop_d = 1'b0;
                if (start_ok) begin
                    if ({tgt_r_i, tgt_g_i, tgt_b_i} == cur_o) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        timer_d = per_new - ONE;
                    end
                end
            end

            ST_WAIT: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - ONE;
                end else begin
                    for (int c = 0; c < 3; c++) begin
                        nxt_d[c]  = step_toward(cur_q[c], tgt_q[c]);
                        pend_d[c] = (nxt_d[c] != cur_q[c]);
                    end
                    if (pend_d != 3'b000) begin
                        state_d = ST_WRITE;
                        ch_d    = first_idx(pend_d);
                        adr_d   = {2'b00, ch_d};
                        dat_d   = nxt_d[ch_d];
                    end else begin
                        // A retarget onto the current colour leaves nothing to write.
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_WRITE: begin
                if (stop_i) stop_d = 1'b1;
                if (wb_ack_i) begin
                    cur_d[ch_q]  = nxt_q[ch_q];
                    pend_d[ch_q] = 1'b0;
                    if (stop_q || stop_i) begin
                        state_d = ST_IDLE;
                        stop_d  = 1'b0;
                    end else if (pend_d != 3'b000) begin
                        ch_d  = first_idx(pend_d);
                        adr_d = {2'b00, ch_d};
                        dat_d = nxt_q[ch_d];
                    end else if ({cur_d[0], cur_d[1], cur_d[2]} ==
                                 {tgt_q[0], tgt_q[1], tgt_q[2]}) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                        timer_d = per_q - ONE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments only; the small
    // per-channel arrays are ordinary flops and are cleared like any other.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            for (int c = 0; c < 3; c++) begin
                cur_q[c] <= '0;
                tgt_q[c] <= '0;
                nxt_q[c] <= '0;
            end
            pend_q  <= '0;
            ch_q    <= '0;
            per_q   <= ONE;
            timer_q <= '0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            for (int c = 0; c < 3; c++) begin
                cur_q[c] <= cur_d[c];
                tgt_q[c] <= tgt_d[c];
                nxt_q[c] <= nxt_d[c];
            end
            pend_q  <= pend_d;
            ch_q    <= ch_d;
            per_q   <= per_d;
            timer_q <= timer_d;
            stop_q  <= stop_d;
            done_q  <= done_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
        end
    end

endmodule
